// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the accumulator core: steps each instruction
// through FETCH/EXEC/MEM, drives datapath strobes, and keeps busy/retire counters.
module ctrl_sequencer #(
  parameter int              OPW      = 4,
  parameter int              MEM_LAT  = 1,
  parameter int              CNT_W    = 16,
  parameter logic [OPW-1:0]  OP_LOAD  = OPW'(4'b0000),
  parameter logic [OPW-1:0]  OP_STORE = OPW'(4'b0001),
  parameter logic [OPW-1:0]  OP_MOV   = OPW'(4'b0010),
  parameter logic [OPW-1:0]  OP_BR_LO = OPW'(4'b1100),
  parameter logic [OPW-1:0]  OP_BR_HI = OPW'(4'b1110),
  parameter logic [OPW-1:0]  OP_HALT  = OPW'(4'b1111)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [OPW-1:0]   opcode,
  input  logic             identifier,
  output logic             InstrLoad,
  output logic             PCEn,
  output logic             RegWrite,
  output logic             AccWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Lookup,
  output logic             ImmVal,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;
  typedef enum logic [2:0] {C_ALU, C_MOV, C_BR, C_LOAD, C_STORE, C_HALT} op_class_e;

  localparam logic [3:0]       WAIT_INIT = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  function automatic op_class_e classify(input logic [OPW-1:0] op);
    if (op == OP_LOAD)                        return C_LOAD;
    else if (op == OP_STORE)                  return C_STORE;
    else if (op == OP_MOV)                    return C_MOV;
    else if (op == OP_HALT)                   return C_HALT;
    else if (op >= OP_BR_LO && op <= OP_BR_HI) return C_BR;
    return C_ALU;
  endfunction

  state_e           state_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;
  logic [3:0]       wait_q;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  op_class_e        cls;
  logic             cur_id;
  logic             last_mem;

  // EXEC decodes the live opcode; MEM relies on the copy latched at the end of EXEC.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    InstrLoad = 1'b0;
    PCEn      = 1'b0;
    RegWrite  = 1'b0;
    AccWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Branch    = 1'b0;
    Lookup    = 1'b0;
    ImmVal    = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    cls       = classify((state_q == S_EXEC) ? opcode : op_q);
    cur_id    = (state_q == S_EXEC) ? identifier : id_q;
    last_mem  = (state_q == S_MEM) ? (wait_q == 4'd0) : (MEM_LAT == 0);

    case (state_q)
      S_FETCH: begin
        InstrLoad = 1'b1;
        Busy      = 1'b1;
      end
      S_EXEC, S_MEM: begin
        Busy = 1'b1;
        case (cls)
          C_ALU: begin
            AccWrite = 1'b1;
            ImmVal   = cur_id;
            PCEn     = 1'b1;
          end
          C_MOV: begin
            RegWrite = 1'b1;
            PCEn     = 1'b1;
          end
          C_BR: begin
            Branch = 1'b1;
            Lookup = 1'b1;
            PCEn   = 1'b1;
          end
          C_LOAD: begin
            MemRead  = 1'b1;
            ImmVal   = cur_id;
            AccWrite = last_mem;
            PCEn     = last_mem;
          end
          C_STORE: begin
            MemWrite = 1'b1;
            PCEn     = last_mem;
          end
          default: ;
        endcase
      end
      S_HALT:  Done = 1'b1;
      default: ;
    endcase

    cycle_d = (Busy && cycle_q != CNT_MAX) ? cycle_q + 1'b1 : cycle_q;
    instr_d = (PCEn && instr_q != CNT_MAX) ? instr_q + 1'b1 : instr_q;
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      id_q    <= 1'b0;
      wait_q  <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (Start) begin
            state_q <= S_FETCH;
            cycle_q <= '0;
            instr_q <= '0;
          end
        end
        S_FETCH: state_q <= S_EXEC;
        S_EXEC: begin
          op_q <= opcode;
          id_q <= identifier;
          case (cls)
            C_LOAD, C_STORE: begin
              if (MEM_LAT == 0) begin
                state_q <= S_FETCH;
              end else begin
                wait_q  <= WAIT_INIT;
                state_q <= S_MEM;
              end
            end
            C_HALT:  state_q <= S_HALT;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (wait_q != 4'd0) wait_q  <= wait_q - 1'b1;
          else                state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CycleCount = cycle_q;
  assign InstrCount = instr_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: four instances (MEM_LAT 0..3, last one with 4-bit counters)
// compared cycle by cycle against an instruction-level schedule model.
module tb_ctrl_sequencer;

  localparam logic [10:0] M_IL = 11'd1 << 10;
  localparam logic [10:0] M_PC = 11'd1 << 9;
  localparam logic [10:0] M_RW = 11'd1 << 8;
  localparam logic [10:0] M_AW = 11'd1 << 7;
  localparam logic [10:0] M_MR = 11'd1 << 6;
  localparam logic [10:0] M_MW = 11'd1 << 5;
  localparam logic [10:0] M_BR = 11'd1 << 4;
  localparam logic [10:0] M_LU = 11'd1 << 3;
  localparam logic [10:0] M_IM = 11'd1 << 2;
  localparam logic [10:0] M_BZ = 11'd1 << 1;
  localparam logic [10:0] M_DN = 11'd1;

  localparam int K_ALU = 0, K_MOV = 1, K_BR = 2, K_LOAD = 3, K_STORE = 4, K_HALT = 5;

  typedef struct {
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic        id;
    logic [10:0] vec;
    logic        clr;
  } ent_t;

  ent_t sched[$];

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       identifier = 1'b0;

  logic [10:0] vec_w [4];
  logic [15:0] cyc_w [4];
  logic [15:0] ins_w [4];

  int checks = 0;
  int failures = 0;
  int m_cyc = 0;
  int m_ins = 0;

  logic [10:0] ov;
  logic [15:0] oc, oi, ec, ei;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = (g == 3) ? 4 : 16;
    logic il, pc, rw, aw, mr, mw, br, lu, im, bz, dn;
    logic [CW-1:0] cc, ic;
    ctrl_sequencer #(.MEM_LAT(g), .CNT_W(CW)) u_dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .opcode(opcode), .identifier(identifier),
      .InstrLoad(il), .PCEn(pc), .RegWrite(rw), .AccWrite(aw), .MemRead(mr), .MemWrite(mw),
      .Branch(br), .Lookup(lu), .ImmVal(im), .Busy(bz), .Done(dn),
      .CycleCount(cc), .InstrCount(ic)
    );
    assign vec_w[g] = {il, pc, rw, aw, mr, mw, br, lu, im, bz, dn};
    assign cyc_w[g] = 16'(cc);
    assign ins_w[g] = 16'(ic);
  end

  function automatic int cnt_max(input int k);
    return (k == 3) ? 15 : 65535;
  endfunction

  function automatic int op_kind(input logic [3:0] op);
    if (op == 4'd0)       return K_LOAD;
    else if (op == 4'd1)  return K_STORE;
    else if (op == 4'd2)  return K_MOV;
    else if (op == 4'd15) return K_HALT;
    else if (op >= 4'd12) return K_BR;
    return K_ALU;
  endfunction

  function automatic ent_t mk(input logic start, input logic [10:0] vec, input logic clr);
    ent_t e;
    e.rst   = 1'b0;
    e.start = start;
    e.op    = 4'($urandom);
    e.id    = 1'($urandom);
    e.vec   = vec;
    e.clr   = clr;
    return e;
  endfunction

  function automatic logic poke(input bit en);
    return en && ($urandom_range(0, 3) == 0);
  endfunction

  task automatic plan_go(input bit from_halt);
    sched.push_back(mk(1'b1, from_halt ? M_DN : 11'd0, 1'b1));
  endtask

  task automatic plan_halted(input int n);
    for (int i = 0; i < n; i++) sched.push_back(mk(1'b0, M_DN, 1'b0));
  endtask

  // One instruction as the per-cycle strobe pattern it must produce.
  task automatic plan_instr(input int lat, input logic [3:0] op, input logic id, input bit pokes);
    int          kind;
    logic [10:0] v;
    ent_t        e;
    kind = op_kind(op);
    sched.push_back(mk(poke(pokes), M_IL | M_BZ, 1'b0));
    v = M_BZ;
    case (kind)
      K_ALU:   v |= M_AW | M_PC | (id ? M_IM : 11'd0);
      K_MOV:   v |= M_RW | M_PC;
      K_BR:    v |= M_BR | M_LU | M_PC;
      K_LOAD:  v |= M_MR | (id ? M_IM : 11'd0) | ((lat == 0) ? (M_AW | M_PC) : 11'd0);
      K_STORE: v |= M_MW | ((lat == 0) ? M_PC : 11'd0);
      default: ;
    endcase
    e = mk(poke(pokes), v, 1'b0);
    e.op = op;
    e.id = id;
    sched.push_back(e);
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int j = 1; j <= lat; j++) begin
        v = M_BZ | ((kind == K_LOAD) ? (M_MR | (id ? M_IM : 11'd0)) : M_MW);
        if (j == lat) v |= M_PC | ((kind == K_LOAD) ? M_AW : 11'd0);
        sched.push_back(mk(poke(pokes), v, 1'b0));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    m_cyc = 0;
    m_ins = 0;
    sched.delete();
  endtask

  // Drives one cycle, samples instance k, and advances the counter model across the edge.
  task automatic drive_sample(input int k, input ent_t e,
                              output logic [10:0] o_v, output logic [15:0] o_c, output logic [15:0] o_i,
                              output logic [15:0] e_c, output logic [15:0] e_i);
    @(negedge Clk);
    Reset      = e.rst;
    Start      = e.start;
    opcode     = e.op;
    identifier = e.id;
    #1;
    o_v = vec_w[k];
    o_c = cyc_w[k];
    o_i = ins_w[k];
    e_c = 16'(m_cyc);
    e_i = 16'(m_ins);
    if (e.rst || e.clr) begin
      m_cyc = 0;
      m_ins = 0;
    end else begin
      if ((e.vec & M_BZ) != 11'd0 && m_cyc < cnt_max(k)) m_cyc++;
      if ((e.vec & M_PC) != 11'd0 && m_ins < cnt_max(k)) m_ins++;
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({vec_w[k], cyc_w[k], ins_w[k]} !== 43'd0) begin
        failures++;
        $display("FAIL reset[%0d]: got vec=%b cyc=%0d ins=%0d, want all zero", k, vec_w[k], cyc_w[k], ins_w[k]);
      end
    end
  endtask

  task automatic test_alu();
    do_reset();
    plan_go(1'b0);
    plan_instr(2, 4'b0011, 1'b1, 1'b0);
    plan_instr(2, 4'b1111, 1'b0, 1'b0);
    plan_halted(2);
    foreach (sched[i]) begin
      drive_sample(2, sched[i], ov, oc, oi, ec, ei);
      checks++;
      if ({ov, oc, oi} !== {sched[i].vec, ec, ei}) begin
        failures++;
        $display("FAIL alu[%0d]: got vec=%b cyc=%0d ins=%0d, want vec=%b cyc=%0d ins=%0d", i, ov, oc, oi, sched[i].vec, ec, ei);
      end
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    plan_go(1'b0);
    plan_instr(2, 4'b0000, 1'b0, 1'b0);
    plan_instr(2, 4'b1111, 1'b0, 1'b0);
    plan_halted(2);
    foreach (sched[i]) begin
      drive_sample(2, sched[i], ov, oc, oi, ec, ei);
      checks++;
      if ({ov, oc, oi} !== {sched[i].vec, ec, ei}) begin
        failures++;
        $display("FAIL load_wait[%0d]: got vec=%b cyc=%0d ins=%0d, want vec=%b cyc=%0d ins=%0d", i, ov, oc, oi, sched[i].vec, ec, ei);
      end
    end
  endtask

  task automatic test_store_nowait();
    do_reset();
    plan_go(1'b0);
    plan_instr(0, 4'b0001, 1'b1, 1'b0);
    plan_instr(0, 4'b0000, 1'b1, 1'b0);
    plan_instr(0, 4'b1111, 1'b0, 1'b0);
    plan_halted(1);
    foreach (sched[i]) begin
      drive_sample(0, sched[i], ov, oc, oi, ec, ei);
      checks++;
      if ({ov, oc, oi} !== {sched[i].vec, ec, ei}) begin
        failures++;
        $display("FAIL store_nowait[%0d]: got vec=%b cyc=%0d ins=%0d, want vec=%b cyc=%0d ins=%0d", i, ov, oc, oi, sched[i].vec, ec, ei);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    plan_go(1'b0);
    plan_instr(1, 4'b1101, 1'b1, 1'b0);
    plan_instr(1, 4'b0010, 1'b1, 1'b0);
    plan_instr(1, 4'b1111, 1'b0, 1'b0);
    plan_halted(1);
    foreach (sched[i]) begin
      drive_sample(1, sched[i], ov, oc, oi, ec, ei);
      checks++;
      if ({ov, oc, oi} !== {sched[i].vec, ec, ei}) begin
        failures++;
        $display("FAIL branch[%0d]: got vec=%b cyc=%0d ins=%0d, want vec=%b cyc=%0d ins=%0d", i, ov, oc, oi, sched[i].vec, ec, ei);
      end
    end
  endtask

  task automatic test_halt_restart();
    do_reset();
    plan_go(1'b0);
    plan_instr(1, 4'b0101, 1'b0, 1'b0);
    plan_instr(1, 4'b0000, 1'b1, 1'b0);
    plan_instr(1, 4'b1111, 1'b0, 1'b0);
    plan_halted(3);
    plan_go(1'b1);
    plan_instr(1, 4'b1000, 1'b1, 1'b0);
    plan_instr(1, 4'b1111, 1'b0, 1'b0);
    plan_halted(2);
    foreach (sched[i]) begin
      drive_sample(1, sched[i], ov, oc, oi, ec, ei);
      checks++;
      if ({ov, oc, oi} !== {sched[i].vec, ec, ei}) begin
        failures++;
        $display("FAIL halt_restart[%0d]: got vec=%b cyc=%0d ins=%0d, want vec=%b cyc=%0d ins=%0d", i, ov, oc, oi, sched[i].vec, ec, ei);
      end
    end
  endtask

  task automatic test_reset_in_mem();
    do_reset();
    plan_go(1'b0);
    plan_instr(3, 4'b0000, 1'b1, 1'b0);
    while (sched.size() > 4) void'(sched.pop_back());
    sched[3].rst   = 1'b1;
    sched[3].start = 1'b1;
    sched.push_back(mk(1'b0, 11'd0, 1'b0));
    sched.push_back(mk(1'b0, 11'd0, 1'b0));
    foreach (sched[i]) begin
      drive_sample(3, sched[i], ov, oc, oi, ec, ei);
      checks++;
      if ({ov, oc, oi} !== {sched[i].vec, ec, ei}) begin
        failures++;
        $display("FAIL reset_in_mem[%0d]: got vec=%b cyc=%0d ins=%0d, want vec=%b cyc=%0d ins=%0d", i, ov, oc, oi, sched[i].vec, ec, ei);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    plan_go(1'b0);
    for (int n = 0; n < 10; n++) plan_instr(3, 4'b0100, 1'($urandom), 1'b0);
    plan_instr(3, 4'b1111, 1'b0, 1'b0);
    plan_halted(2);
    foreach (sched[i]) begin
      drive_sample(3, sched[i], ov, oc, oi, ec, ei);
      checks++;
      if ({ov, oc, oi} !== {sched[i].vec, ec, ei}) begin
        failures++;
        $display("FAIL saturation[%0d]: got vec=%b cyc=%0d ins=%0d, want vec=%b cyc=%0d ins=%0d", i, ov, oc, oi, sched[i].vec, ec, ei);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      plan_go(1'b0);
      for (int n = 0; n < 25; n++) begin
        op = 4'($urandom);
        plan_instr(k, op, 1'($urandom), 1'b1);
        if (op == 4'd15) begin
          plan_halted($urandom_range(0, 2));
          plan_go(1'b1);
        end
      end
      plan_instr(k, 4'b1111, 1'b0, 1'b1);
      plan_halted(2);
      foreach (sched[i]) begin
        drive_sample(k, sched[i], ov, oc, oi, ec, ei);
        checks++;
        if ({ov, oc, oi} !== {sched[i].vec, ec, ei}) begin
          failures++;
          $display("FAIL back_to_back[%0d][%0d]: got vec=%b cyc=%0d ins=%0d, want vec=%b cyc=%0d ins=%0d", k, i, ov, oc, oi, sched[i].vec, ec, ei);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store_nowait();
    test_branch();
    test_halt_restart();
    test_reset_in_mem();
    test_saturation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1);
  end

endmodule
